acc_datapath: RTL and testbench
===============================

ACC_DATAPATH -- requirements
Module: acc_datapath

Interface
REQ-001 SHALL provide parameter n, default 8, the datapath word width in bits.
REQ-002 SHALL provide parameter cw, default 4, the width of the loop-count input.
REQ-003 SHALL provide port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port Aload  input  1  single-step load enable for A.
REQ-006 SHALL provide port Sub  input  1  ALU mode: 0 selects A+B, 1 selects A-B.
REQ-007 SHALL provide port Asel  input  2  A source select.
REQ-008 SHALL provide port dp1In  input  n  external operand.
REQ-009 SHALL provide port mInput  input  n  ALU operand B.
REQ-010 SHALL provide port Oload  input  1  output-register load enable.
REQ-011 SHALL provide port start  input  1  loop-mode start request.
REQ-012 SHALL provide port count  input  cw  loop iteration count.
REQ-013 SHALL provide port A  output  n  accumulator register.
REQ-014 SHALL provide port Apos  output  1  A strictly positive in two's complement.
REQ-015 SHALL provide port Aeq0  output  1  A equals zero.
REQ-016 SHALL provide port ovf  output  1  signed overflow of the most recent ALU write.
REQ-017 SHALL provide port mOutput  output  n  output register.
REQ-018 SHALL provide port busy  output  1  loop mode active.
REQ-019 SHALL provide port done  output  1  one-cycle loop-completion pulse.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-021 SHALL compute the ALU result as A+B or A-B, truncated to n bits with wrap-around; B is mInput in IDLE and the latched operand in RUN.
REQ-022 SHALL, in IDLE with Aload=1 and start=0, load A from Asel: 0 -> dp1In, 1 -> ALU result, 2 -> mInput, 3 -> all zeros.
REQ-023 SHALL drive Aeq0 = (A==0) and Apos = (A[n-1]==0) and (A!=0), both combinationally from A.
REQ-024 SHALL update ovf only on an ALU write to A (Asel=1 load, or a RUN step), setting it to that operation's signed overflow; otherwise ovf holds.
REQ-025 SHALL load mOutput with the current A on any cycle with Oload=1, in every state.
REQ-026 SHALL, in IDLE with start=1 and count>0, latch mInput, Sub and count, and enter RUN; start wins over a simultaneous Aload.
REQ-027 SHALL, in IDLE with start=1 and count=0, enter DONE with A unchanged.
REQ-028 SHALL, in RUN, write the ALU result to A each cycle and decrement the latched count; after the count-th write, enter DONE.
REQ-029 SHALL hold busy=1 exactly while in RUN.
REQ-030 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-031 SHALL ignore Aload, start, Sub, count and mInput changes while in RUN or DONE.

Reset
REQ-032 SHALL, on reset=0, immediately and regardless of clock force: IDLE, A=0, mOutput=0, ovf=0, busy=0, done=0, latched operand/count=0; hence Aeq0=1 and Apos=0.
REQ-033 SHALL abort an in-progress loop on reset, with no done pulse generated.

Verification
REQ-034 SHALL cover reset: hold reset=0 -> A=0, mOutput=0, Aeq0=1, Apos=0, busy=0, done=0, ovf=0.
REQ-035 SHALL cover single-step: Asel=0, dp1In=20, Aload -> A=20, Apos=1; then Asel=1, Sub=1, mInput=10 on three loads -> A=10, then 0 (Aeq0=1), then 0xF6 (Apos=0, ovf=0).
REQ-036 SHALL cover loop mode: A=20, start, count=3, mInput=10, Sub=0 -> busy for 3 cycles, A=30,40,50, done=1 for the following cycle, final A=50.
REQ-037 SHALL cover zero count: start with count=0 -> busy never asserted, done=1 on the next cycle, A unchanged.
REQ-038 SHALL cover overflow and output: A=120, Asel=1, Sub=0, mInput=10, Aload -> A=0x82, ovf=1, Apos=0; Oload -> mOutput=0x82.
REQ-039 SHALL cover mid-loop reset: reset=0 on the 2nd RUN cycle of a count=5 loop -> A=0, busy=0 at once, no done pulse after release.

Source files
------------

// File: rtl/acc_datapath.sv
// Accumulator datapath with an add/subtract ALU, output register and
// a counted loop mode that repeatedly applies a latched operand to A.
module acc_datapath #(
   parameter int n  = 8,
   parameter int cw = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          Aload,
   input  logic          Sub,
   input  logic [1:0]    Asel,
   input  logic [n-1:0]  dp1In,
   input  logic [n-1:0]  mInput,
   input  logic          Oload,
   input  logic          start,
   input  logic [cw-1:0] count,
   output logic [n-1:0]  A,
   output logic          Apos,
   output logic          Aeq0,
   output logic          ovf,
   output logic [n-1:0]  mOutput,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [n-1:0]  b_lat;
   logic          sub_lat;
   logic [cw-1:0] cnt;
   logic [n-1:0]  alu_b, alu_r;
   logic          alu_sub, alu_ovf;

   // In RUN the ALU uses the operand and mode captured at start
   always_comb begin
      alu_b   = (state == RUN) ? b_lat : mInput;
      alu_sub = (state == RUN) ? sub_lat : Sub;
      alu_r   = alu_sub ? (A - alu_b) : (A + alu_b);
      if (alu_sub)
         alu_ovf = (A[n-1] != alu_b[n-1]) && (alu_r[n-1] != A[n-1]);
      else
         alu_ovf = (A[n-1] == alu_b[n-1]) && (alu_r[n-1] != A[n-1]);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_nx = (count != '0) ? RUN : DONE;
         end
         RUN: begin
            if (cnt == cw'(1))
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         A       <= '0;
         mOutput <= '0;
         ovf     <= 1'b0;
         b_lat   <= '0;
         sub_lat <= 1'b0;
         cnt     <= '0;
      end else begin
         if (Oload)
            mOutput <= A;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (count != '0) begin
                     b_lat   <= mInput;
                     sub_lat <= Sub;
                     cnt     <= count;
                  end
               end else if (Aload) begin
                  unique case (Asel)
                     2'd0: A <= dp1In;
                     2'd1: begin
                        A   <= alu_r;
                        ovf <= alu_ovf;
                     end
                     2'd2: A <= mInput;
                     2'd3: A <= '0;
                     default: A <= '0;
                  endcase
               end
            end
            RUN: begin
               A   <= alu_r;
               ovf <= alu_ovf;
               cnt <= cnt - cw'(1);
            end
            default: ;
         endcase
      end
   end

   assign Aeq0 = (A == '0);
   assign Apos = !A[n-1] && (A != '0);
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_acc_datapath.sv
// Directed and random checks of acc_datapath against a cycle-level
// arithmetic model of accumulator, loop counter and done pulse.
module tb_acc_datapath;

   localparam int N    = 8;
   localparam int CW   = 4;
   localparam int MOD  = 2 ** N;
   localparam int HALF = 2 ** (N - 1);

   logic          clock = 1'b0;
   logic          reset;
   logic          Aload, Sub, Oload, start;
   logic [1:0]    Asel;
   logic [N-1:0]  dp1In, mInput;
   logic [CW-1:0] count;
   logic [N-1:0]  A, mOutput;
   logic          Apos, Aeq0, ovf, busy, done;

   int errors = 0;
   int checks = 0;

   // model state
   int m_a, m_out, m_rem, m_lb;
   bit m_ovf, m_done, m_ls;

   acc_datapath #(.n(N), .cw(CW)) dut (
      .clock(clock), .reset(reset), .Aload(Aload), .Sub(Sub),
      .Asel(Asel), .dp1In(dp1In), .mInput(mInput), .Oload(Oload),
      .start(start), .count(count), .A(A), .Apos(Apos), .Aeq0(Aeq0),
      .ovf(ovf), .mOutput(mOutput), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sx(input int v);
      return (v >= HALF) ? v - MOD : v;
   endfunction

   // signed arithmetic, wrap and overflow from the true result range
   task automatic alu(input int b, input bit s, output int r, output bit o);
      int t;
      t = s ? sx(m_a) - sx(b) : sx(m_a) + sx(b);
      o = (t >= HALF) || (t < -HALF);
      r = ((t % MOD) + MOD) % MOD;
   endtask

   task automatic model_reset();
      m_a = 0; m_out = 0; m_rem = 0; m_lb = 0;
      m_ovf = 0; m_done = 0; m_ls = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".A"}, int'(A), m_a);
      chk({tag, ".mOutput"}, int'(mOutput), m_out);
      chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
      chk({tag, ".busy"}, int'(busy), int'(m_rem > 0));
      chk({tag, ".done"}, int'(done), int'(m_done));
      chk({tag, ".Aeq0"}, int'(Aeq0), int'(m_a == 0));
      chk({tag, ".Apos"}, int'(Apos), int'(m_a != 0 && m_a < HALF));
   endtask

   // one clock: model advances from pre-edge inputs, then outputs compared
   task automatic cyc(input string tag);
      int r, na, nout, nrem;
      bit o, novf, ndone;
      na = m_a; novf = m_ovf; nrem = m_rem; ndone = 0;
      nout = Oload ? m_a : m_out;
      if (m_done) begin
         ndone = 0;
      end else if (m_rem > 0) begin
         alu(m_lb, m_ls, r, o);
         na = r; novf = o; nrem = m_rem - 1;
         ndone = (nrem == 0);
      end else if (start) begin
         if (count > 0) begin
            m_lb = int'(mInput); m_ls = Sub; nrem = int'(count);
         end else begin
            ndone = 1;
         end
      end else if (Aload) begin
         case (Asel)
            2'd0: na = int'(dp1In);
            2'd1: begin
               alu(int'(mInput), Sub, r, o);
               na = r; novf = o;
            end
            2'd2: na = int'(mInput);
            default: na = 0;
         endcase
      end
      @(posedge clock);
      #1;
      m_a = na; m_ovf = novf; m_rem = nrem; m_done = ndone; m_out = nout;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      Aload = 0; Sub = 0; Asel = 0; dp1In = 0; mInput = 0;
      Oload = 0; start = 0; count = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 0;
      model_reset();
      #2;
      check_all("reset");
      chk("reset.Aeq0_const", int'(Aeq0), 1);
      @(negedge clock);
      reset = 1;

      // single step
      Asel = 0; dp1In = 20; Aload = 1;
      cyc("ld20");
      chk("ld20.A_const", int'(A), 20);
      chk("ld20.Apos_const", int'(Apos), 1);
      Asel = 1; Sub = 1; mInput = 10;
      cyc("sub1");
      chk("sub1.A_const", int'(A), 10);
      cyc("sub2");
      chk("sub2.Aeq0_const", int'(Aeq0), 1);
      cyc("sub3");
      chk("sub3.A_const", int'(A), 'hF6);
      chk("sub3.ovf_const", int'(ovf), 0);

      // loop mode
      Asel = 0; dp1In = 20; Sub = 0;
      cyc("ld20b");
      Aload = 0; start = 1; count = 3; mInput = 10;
      cyc("lp_start");
      start = 0; count = 0; mInput = 0; Sub = 1;
      cyc("lp1");
      chk("lp1.A_const", int'(A), 30);
      cyc("lp2");
      chk("lp2.A_const", int'(A), 40);
      cyc("lp3");
      chk("lp3.A_const", int'(A), 50);
      chk("lp3.done_const", int'(done), 1);
      cyc("lp_idle");
      Sub = 0;

      // zero count
      start = 1; count = 0;
      cyc("z_start");
      chk("z.done_const", int'(done), 1);
      chk("z.busy_const", int'(busy), 0);
      start = 0;
      cyc("z_idle");

      // overflow and output
      Aload = 1; Asel = 2; mInput = 120;
      cyc("ld120");
      Asel = 1; Sub = 0; mInput = 10;
      cyc("ovf_add");
      chk("ovf.A_const", int'(A), 'h82);
      chk("ovf.ovf_const", int'(ovf), 1);
      Aload = 0; Oload = 1;
      cyc("oload");
      chk("oload.mOutput_const", int'(mOutput), 'h82);
      Oload = 0;

      // mid-loop reset
      Aload = 1; Asel = 0; dp1In = 7;
      cyc("ld7");
      Aload = 0; start = 1; count = 5; mInput = 3;
      cyc("mr_start");
      start = 0;
      cyc("mr_run2");
      reset = 0;
      #1;
      model_reset();
      check_all("mr_async");
      @(negedge clock);
      reset = 1;
      for (int i = 0; i < 4; i++) cyc("mr_after");

      // random
      for (int i = 0; i < 400; i++) begin
         Aload  = 1'($urandom_range(0, 1));
         Sub    = 1'($urandom_range(0, 1));
         Asel   = 2'($urandom_range(0, 3));
         dp1In  = N'($urandom);
         mInput = N'($urandom);
         Oload  = 1'($urandom_range(0, 1));
         start  = ($urandom_range(0, 7) == 0);
         count  = CW'($urandom_range(0, 4));
         cyc("rand");
      end

      idle_inputs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
